// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO-to-SRAM drain engine.
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_REQ,
        S_POLL_CAP,
        S_GAP,
        S_READ,
        S_WRITE,
        S_FIN
    } state_e;

    localparam logic [2:0] CSR_FILL_LEVEL = 3'd0;
    localparam logic [2:0] CSR_I_STATUS   = 3'd1;
    localparam logic [3:0] SRAM_BE_ALL    = 4'hF;

endpackage

// File: rtl/fifo_drain_to_sram.sv
// Pops LEN words from the HPS-to-FPGA FIFO into on-chip SRAM from BASE.
// Optional empty-poll watchdog: define FIFO_DRAIN_TIMEOUT_EN.
module fifo_drain_to_sram
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SRAM_AW  = 8,
    parameter int POLL_GAP = 16
`ifdef FIFO_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               start,
    input  logic [SRAM_AW-1:0] base_addr,
    input  logic [SRAM_AW:0]   len,
    output logic               busy,
    output logic               done,
    output logic [SRAM_AW:0]   words_done,
`ifdef FIFO_DRAIN_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               fifo_out_read,
    input  logic [DATA_W-1:0]  fifo_out_readdata,
    input  logic               fifo_out_waitrequest,
    output logic [2:0]         fifo_csr_address,
    output logic               fifo_csr_read,
    output logic               fifo_csr_write,
    output logic [31:0]        fifo_csr_writedata,
    input  logic [31:0]        fifo_csr_readdata,
    output logic [SRAM_AW-1:0] sram_address,
    output logic               sram_clken,
    output logic               sram_chipselect,
    output logic               sram_write,
    output logic [DATA_W-1:0]  sram_writedata,
    output logic [3:0]         sram_byteenable
);

    localparam int LW = SRAM_AW + 1;

    state_e             state_q, state_d;
    logic [SRAM_AW-1:0] base_q, base_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic [LW-1:0]      burst_q, burst_d;
    logic [LW-1:0]      wd_q, wd_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [15:0]        gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic               tmo_q, tmo_d;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            burst_q <= burst_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rem_d   = rem_q;
        burst_d = burst_q;
        wd_d    = wd_q;
        data_d  = data_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    rem_d   = len;
                    wd_d    = '0;
                    busy_d  = 1'b1;
                    state_d = (len == '0) ? S_FIN : S_POLL_REQ;
`ifdef FIFO_DRAIN_TIMEOUT_EN
                    tmo_cnt_d = '0;
                    tmo_d     = 1'b0;
`endif
                end
            end
            S_POLL_REQ: state_d = S_POLL_CAP;
            S_POLL_CAP: begin
                if (fifo_csr_readdata == '0) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    // Never pop more than the job still needs.
                    if (fifo_csr_readdata >= 32'(rem_q))
                        burst_d = rem_q;
                    else
                        burst_d = fifo_csr_readdata[LW-1:0];
                    state_d = S_READ;
                end
            end
            S_GAP: begin
                if (gap_q == 16'(POLL_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_POLL_REQ;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_READ: begin
                if (!fifo_out_waitrequest) begin
                    data_d  = fifo_out_readdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wd_d    = wd_q + LW'(1);
                rem_d   = rem_q - LW'(1);
                burst_d = burst_q - LW'(1);
                if (rem_q == LW'(1))
                    state_d = S_FIN;
                else if (burst_q > LW'(1))
                    state_d = S_READ;
                else
                    state_d = S_POLL_REQ;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FIFO_DRAIN_TIMEOUT_EN
        // Watchdog only runs while starved; any accepted pop rearms it.
        if (state_q == S_GAP || state_q == S_POLL_REQ ||
            state_q == S_POLL_CAP) begin
            if (tmo_cnt_q >= 32'(TIMEOUT_CYC - 1)) begin
                tmo_cnt_d = '0;
                tmo_d     = 1'b1;
                state_d   = S_FIN;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end else if (state_q == S_READ && !fifo_out_waitrequest) begin
            tmo_cnt_d = '0;
        end
`endif
    end

    logic wr_cyc;
    assign wr_cyc = (state_q == S_WRITE);

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = wd_q;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    assign timeout    = tmo_q;
`endif

    assign fifo_out_read      = (state_q == S_READ);
    assign fifo_csr_address   = CSR_FILL_LEVEL;
    assign fifo_csr_read      = (state_q == S_POLL_REQ);
    assign fifo_csr_write     = 1'b0;
    assign fifo_csr_writedata = '0;

    assign sram_clken      = 1'b1;
    assign sram_chipselect = wr_cyc;
    assign sram_write      = wr_cyc;
    assign sram_address    = base_q + wd_q[SRAM_AW-1:0];
    assign sram_writedata  = wr_cyc ? data_q : '0;
    assign sram_byteenable = SRAM_BE_ALL;

endmodule

// File: doc/fifo_drain_to_sram.md
Name: fifo_drain_to_sram

Overview:
- FPGA-side consumer for the HPS-to-FPGA Avalon FIFO. The HPS pushes words into the FIFO, and this block pops them.
- On a start pulse, it polls the FIFO CSR fill level, pops exactly LEN words through the FIFO output slave, and writes each word into the on-chip SRAM s1 port at consecutive addresses from BASE, wrapping at the SRAM depth.
- It sits in the top-level fabric next to the Computer_System instance, on the same clock as the FIFO output and SRAM ports.

Parameters:
- DATA_W, 32, FIFO and SRAM word width.
- SRAM_AW, 8, SRAM word-address width (256 words).
- POLL_GAP, 16, idle cycles between CSR polls when the FIFO is empty (>=1).
- TIMEOUT_CYC, 65535, empty-poll watchdog limit (used only with the optional feature).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; ignored unless idle.
- base_addr  in  SRAM_AW  first SRAM word address, latched on start.
- len  in  SRAM_AW+1  words to transfer, 0..256, latched on start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at completion.
- words_done  out  SRAM_AW+1  words written in the current or last job.
- fifo_out_read  out  1  Avalon read to the FIFO output slave.
- fifo_out_readdata  in  DATA_W  popped word.
- fifo_out_waitrequest  in  1  stall from the FIFO output slave.
- fifo_csr_address  out  3  CSR address; always 0 (fill_level).
- fifo_csr_read  out  1  CSR read strobe.
- fifo_csr_write  out  1  tied 0.
- fifo_csr_writedata  out  32  tied 0.
- fifo_csr_readdata  in  32  CSR data; fixed read latency of 1.
- sram_address  out  SRAM_AW  s1 address.
- sram_clken  out  1  constant 1 after reset.
- sram_chipselect  out  1  high only during the write cycle.
- sram_write  out  1  write strobe.
- sram_writedata  out  DATA_W  word to write.
- sram_byteenable  out  4  constant 4'hF.

Behaviour:
- Reset: FSM goes to IDLE. All outputs go to 0, except sram_byteenable=4'hF and sram_clken=1. Any in-flight word is discarded, and no partial SRAM write occurs.
- FSM states: IDLE, POLL_REQ, POLL_CAP, GAP, READ, WRITE, FIN.
- IDLE:
  - start=1 latches base_addr, len, remaining=len, words_done=0, and sets busy=1.
  - If len=0, go to FIN; otherwise go to POLL_REQ.
- POLL_REQ: assert fifo_csr_read=1 with address 0 for exactly one cycle, then go to POLL_CAP.
- POLL_CAP:
  - Sample fifo_csr_readdata (latency 1).
  - fill=0: go to GAP.
  - Otherwise: burst=min(fill, remaining), then go to READ.
- GAP: count POLL_GAP cycles, then go to POLL_REQ.
- READ:
  - Hold fifo_out_read=1 until fifo_out_waitrequest=0.
  - In that accept cycle, capture readdata, deassert read the next cycle, and go to WRITE.
  - At most one pop per accepted read; no read is issued while burst=0.
- WRITE:
  - One cycle with sram_chipselect=1, sram_write=1, sram_address=base+words_done (mod 2^SRAM_AW), and sram_writedata = the captured word.
  - Then increment words_done and decrement remaining and burst.
  - remaining=0: go to FIN. burst>0: go to READ. Otherwise go to POLL_REQ.
- FIN: done=1 for one cycle, busy drops on the same cycle, then go to IDLE. words_done holds until the next start.
- Throughput: 2 cycles per word inside a burst, plus 2 cycles per poll.
- Address wrap: base=8'hFE with len=4 writes addresses FE, FF, 00, 01.
- start while busy: ignored, with no effect on the latched job.
- Never more than one of fifo_csr_read, fifo_out_read, or sram_write is active in the same cycle.

Optional Feature:
- Macro: FIFO_DRAIN_TIMEOUT_EN.
- Defined:
  - Adds output timeout (1 bit, sticky until the next accepted start).
  - A counter accumulates cycles spent in GAP/POLL without a pop and clears on every accepted read.
  - Reaching TIMEOUT_CYC forces FIN, sets timeout=1, and pulses done with words_done equal to the partial count.
- Undefined: no timeout port; the block waits indefinitely for data.

Decomposition:
- Package fifo_drain_pkg holds:
  - the state enum;
  - CSR address constants: FILL_LEVEL=0, I_STATUS=1;
  - the byteenable constant.
- No sub-module; a single FSM with datapath registers is sufficient.

Test Plan:
- FIFO preloaded with 8 words 0x100..0x107; start with base=0x10, len=8 -> SRAM[0x10..0x17]=0x100..0x107; one csr_read; done after 8 writes; words_done=8.
- len=0 -> done pulses 2 cycles after start; no csr_read, fifo_out_read or sram_write is ever asserted.
- FIFO empty at start; 3 words pushed 40 cycles later, len=3 -> GAP re-polls every POLL_GAP+2 cycles; all 3 words written; done.
- waitrequest held high for 5 cycles on the 2nd read -> read stays asserted 6 cycles; data written once; no duplicate pop.
- base=0xFE, len=4, FIFO holds 0xA..0xD -> SRAM[FE]=A, [FF]=B, [00]=C, [01]=D.
- reset_reset pulsed mid-burst after 2 of 6 words -> all outputs return to reset values asynchronously; no SRAM write follows; a new start runs a fresh job. With FIFO_DRAIN_TIMEOUT_EN defined, TIMEOUT_CYC=100 and an empty FIFO -> timeout=1, done, words_done=0.
